bit_serializer: RTL and testbench

Parallel-to-serial front end for the lab's serial sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding register, then shifts them out one bit per enabled clock on dout. dout drives the detector's din input directly. An optional idle gap between words is supported, and a bit-rate enable allows slow serial clocks.

---
 rtl/bit_serializer.sv | 134 +++++++++++++
 tb/tb_bit_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-entry holding register feeding a shift register,
// with an optional en-qualified idle gap between words.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 0,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
    localparam logic [7:0]      GapLast = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StGap   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              hold_full_q, hold_full_d;
    logic [WIDTH-1:0]  hold_data_q, hold_data_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              word_done_q, word_done_d;
    logic              accept;
    logic              load;

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        word_done_d = 1'b0;
        load        = 1'b0;

        // Accept is only possible while empty, so it never collides with a load.
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = in_data;
        end

        case (state_q)
            StIdle: begin
                if (en && hold_full_q) load = 1'b1;
            end
            StShift: begin
                if (en) begin
                    if (bit_cnt_q < BitLast) begin
                        shreg_d   = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                                     : {shreg_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        word_done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d   = StGap;
                            gap_cnt_d = 8'd0;
                        end else if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StGap: begin
                if (en) begin
                    if (gap_cnt_q < GapLast) begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shreg_d     = hold_data_q;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
            state_d     = StShift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= 8'd0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        in_ready   = ~rst & ~hold_full_q;
        dout_valid = (state_q == StShift);
        dout       = 1'b0;
        if (state_q == StShift) begin
            dout = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
        end
        busy      = (state_q != StIdle) | hold_full_q;
        word_done = word_done_q;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios on an MSB-first/no-gap instance and an
// LSB-first/GAP=2 instance, plus a randomized run checked against a bit-queue model.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       en = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic rdy, dout, dv, busy, wd;
    logic g_rdy, g_dout, g_dv, g_busy, g_wd;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    int pops, words_acc, wd_seen;
    bit exp_wd;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy), .in_data(in_data),
        .en(en), .dout(dout), .dout_valid(dv), .busy(busy), .word_done(wd)
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(2)) dut_g (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(g_rdy), .in_data(in_data),
        .en(en), .dout(g_dout), .dout_valid(g_dv), .busy(g_busy), .word_done(g_wd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Word already accepted; checks the eight MSB-first bits on the main instance.
    task automatic shift_word(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1({tag, "_dv"}, dv, 1'b1);
            chk1({tag, "_bit"}, dout, w[7-i]);
            chk1({tag, "_wd"}, wd, 1'b0);
        end
    endtask

    task automatic rnd_cycle(input bit gen);
        chk1("rnd_wd", wd, exp_wd);
        if (wd) wd_seen++;
        if (dv) begin
            if (exp_q.size() == 0) chk1("rnd_spurious_valid", dv, 1'b0);
            else chk1("rnd_bit", dout, exp_q[0]);
        end
        en       = gen ? ($urandom_range(0, 9) < 7) : 1'b1;
        in_valid = gen ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data  = 8'($urandom);
        exp_wd   = 1'b0;
        if (dv && en && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            pops++;
            if (pops % 8 == 0) exp_wd = 1'b1;
        end
        if (in_valid && rdy) begin
            words_acc++;
            for (int i = 7; i >= 0; i--) exp_q.push_back(in_data[i]);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then release
        #2;
        chk1("rst_ready", rdy, 1'b0);
        chk1("rst_dout", dout, 1'b0);
        chk1("rst_dv", dv, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        tick();
        chk1("rst_ready_edge", rdy, 1'b0);
        chk1("rst_wd", wd, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rel_ready", rdy, 1'b1);
        chk1("rel_busy", busy, 1'b0);
        chk1("rel_dv", dv, 1'b0);
        chk1("rel_wd", wd, 1'b0);

        // Single word 0xB4
        en = 1'b1;
        in_data = 8'hB4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk1("b4_ready_held", rdy, 1'b0);
        chk1("b4_busy", busy, 1'b1);
        chk1("b4_dv_latency", dv, 1'b0);
        shift_word("b4", 8'hB4);
        tick();
        chk1("b4_done", wd, 1'b1);
        chk1("b4_idle_dv", dv, 1'b0);
        chk1("b4_idle_busy", busy, 1'b0);
        tick();
        chk1("b4_done_pulse", wd, 1'b0);

        // Back-to-back 0xFF, 0x00
        in_data = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_data = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 2) in_valid = 1'b0;
            chk1("b2b_dv", dv, 1'b1);
            chk1("b2b_bit", dout, k <= 8);
            chk1("b2b_wd", wd, k == 9);
            chk1("b2b_ready", rdy, (k == 1) || (k >= 9));
        end
        tick();
        chk1("b2b_done2", wd, 1'b1);
        chk1("b2b_end_dv", dv, 1'b0);
        tick();
        chk1("b2b_done2_pulse", wd, 1'b0);
        chk1("b2b_busy", busy, 1'b0);

        // Stall: 0xA5 with en low for three cycles after the fourth bit
        in_data = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("stall_pre_bit", dout, in_data[7-i]);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("stall_hold_bit", dout, 1'b0);
            chk1("stall_hold_dv", dv, 1'b1);
            chk1("stall_hold_wd", wd, 1'b0);
        end
        en = 1'b1;
        for (int i = 4; i < 8; i++) begin
            tick();
            chk1("stall_post_bit", dout, in_data[7-i]);
            chk1("stall_post_wd", wd, 1'b0);
        end
        tick();
        chk1("stall_done", wd, 1'b1);
        tick();

        // GAP=2, LSB first: 0x01 then 0x80
        do_reset();
        en = 1'b1;
        in_data = 8'h01;
        in_valid = 1'b1;
        tick();
        in_data = 8'h80;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 2) in_valid = 1'b0;
            chk1("gap_dv", g_dv, (k <= 8) || (k >= 11 && k <= 18));
            chk1("gap_bit", g_dout, (k == 1) || (k == 18));
            chk1("gap_wd", g_wd, (k == 9) || (k == 19));
        end
        for (int i = 0; i < 4; i++) tick();
        chk1("gap_idle_busy", g_busy, 1'b0);

        // Reset mid-word of 0xC3 with 0x3C held
        in_data = 8'hC3;
        in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        tick();
        chk1("mid_bit7", dout, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1("mid_bit6", dout, 1'b1);
        chk1("mid_ready_full", rdy, 1'b0);
        tick();
        chk1("mid_bit5", dout, 1'b0);
        tick();
        chk1("mid_bit4", dout, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk1("mid_rst_dv", dv, 1'b0);
        chk1("mid_rst_dout", dout, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ready", rdy, 1'b0);
        chk1("mid_rst_wd", wd, 1'b0);
        tick();
        chk1("mid_rst_busy_edge", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("post_rst_wd", wd, 1'b0);
            chk1("post_rst_dv", dv, 1'b0);
            chk1("post_rst_busy", busy, 1'b0);
            chk1("post_rst_ready", rdy, 1'b1);
        end
        in_data = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        shift_word("5a", 8'h5A);
        tick();
        chk1("5a_done", wd, 1'b1);
        tick();

        // Randomized traffic against the bit-queue model
        do_reset();
        exp_q.delete();
        pops = 0;
        words_acc = 0;
        wd_seen = 0;
        exp_wd = 1'b0;
        for (int i = 0; i < 400; i++) rnd_cycle(1'b1);
        for (int i = 0; i < 40; i++) rnd_cycle(1'b0);
        chk32("rnd_queue_drained", exp_q.size(), 0);
        chk32("rnd_word_done_count", wd_seen, words_acc);
        chk1("rnd_final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
